bit_serial_adder_ctrl: RTL and testbench
========================================

Name: bit_serial_adder_ctrl

Overview:
Controller that time-multiplexes a single 1-bit full-adder stage to add two WIDTH-bit operands, one bit per clock, LSB first.
It owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
It is the sequential companion to the team's combinational full adder and trades throughput for area.
The full-adder equations (sum = a^b^c, carry = ab|ac|bc) are instantiated or inlined inside this block.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only when busy=0
a  input  WIDTH  operand A; captured on the accepting edge only
b  input  WIDTH  operand B; captured on the accepting edge only
cin  input  1  carry-in; captured on the accepting edge only
busy  output  1  high while an operation is in progress (RUN and DONE states)
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result; held until the next result load
cout  output  1  registered carry-out; held with sum

Behaviour:
- Decided: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset:
  - state=IDLE; busy=0; done=0; sum=0; cout=0.
  - Shift registers, carry flip-flop and counter cleared.
  - rst has priority over every other input, including mid-operation. An aborted operation never produces done, and sum/cout go to 0.
- States: IDLE, RUN, DONE (2-bit encoding; unused code goes to IDLE).
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge loads a_sh=a, b_sh=b, carry=cin, cnt=0, acc=0, then moves to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - fa_s = a_sh[0]^b_sh[0]^carry.
  - fa_c = majority(a_sh[0], b_sh[0], carry).
  - acc shifts right with fa_s inserted at acc[WIDTH-1].
  - a_sh and b_sh shift right, zero-filled.
  - carry = fa_c; cnt++.
  - When cnt==WIDTH-1 on this edge: sum = final acc (including this bit), cout = fa_c, state moves to DONE.
  - busy=1.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge unconditionally returns to IDLE.
  - A start asserted during DONE is ignored.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge. The next start can be accepted 1 cycle after done, giving WIDTH+2 cycles per operation back-to-back.
- Ignored start: start while busy=1 has no effect; it is not queued. a, b and cin changing during RUN have no effect.
- Held outputs: sum/cout change only on the result-load edge or reset. Between operations they hold the last result, including while the next operation runs.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt width: $clog2(WIDTH).

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse:
   - busy=1 the cycle after acceptance.
   - done pulses exactly 8 edges after the accepting edge.
   - sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry ripple through all bits).
3. Exhaustive sweep, WIDTH=4, all 512 (a,b,cin) combinations:
   - {cout,sum} == a+b+cin every time.
   - done is exactly one cycle wide each time.
4. start held high continuously with a changing every cycle:
   - Only the operand present at each IDLE acceptance edge is used.
   - done period = WIDTH+2 cycles.
   - start during RUN/DONE is ignored.
5. Assert rst for 1 cycle at bit 3 of an operation (previous result 0x96):
   - Next cycle busy=0, done=0, sum=0x00, cout=0, no late done.
   - A new start afterwards completes correctly (0x01+0x01 -> 0x02).
6. During an operation, check that sum/cout keep the previous result until the load edge, and that done never rises without a preceding accepted start.

Source files
------------

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage reused over WIDTH clocks, LSB first.
// Operands are captured on the start edge; {cout,sum} is loaded once, when the last bit completes.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_nxt;

  assign fa_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign acc_nxt = {fa_s, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          busy  <= 1'b1;
          // Last bit: result registers take the completed accumulator directly.
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= acc_nxt;
            cout  <= fa_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench: stimulus pushes expected {cout,sum}; a forked monitor pops on each done.
module tb_bit_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_cmp;
  int n_fail;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  bit_serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (busy8 !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy8 !== 1'b0) chk("timeout_idle8", 32'(busy8), 32'd0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (busy4 !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy4 !== 1'b0) chk("timeout_idle4", 32'(busy4), 32'd0);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [8:0] exp);
    wait_idle8();
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     input logic [4:0] exp);
    wait_idle4();
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  initial begin
    int edges;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Monitor: every done must match the oldest outstanding expectation.
    fork
      begin
        logic prev8, prev4;
        logic [8:0] e8;
        logic [4:0] e4;
        prev8 = 1'b0; prev4 = 1'b0;
        forever begin
          @(negedge clk);
          if (done8 === 1'b1) begin
            chk("done8_width", 32'(prev8), 32'd0);
            chk("busy8_with_done", 32'(busy8), 32'd1);
            if (q8.size() == 0) begin
              chk("done8_unexpected", 32'(done8), 32'd0);
            end else begin
              e8 = q8.pop_front();
              chk("result8", 32'({cout8, sum8}), 32'(e8));
            end
          end
          if (done4 === 1'b1) begin
            chk("done4_width", 32'(prev4), 32'd0);
            if (q4.size() == 0) begin
              chk("done4_unexpected", 32'(done4), 32'd0);
            end else begin
              e4 = q4.pop_front();
              chk("result4", 32'({cout4, sum4}), 32'(e4));
            end
          end
          prev8 = done8;
          prev4 = done4;
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'({cout8, sum8}), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_sum4", 32'({cout4, sum4}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: latency and handshake
    op8(8'h5A, 8'h3C, 1'b0, 9'h096);
    chk("t1_busy_after_accept", 32'(busy8), 32'd1);
    chk("t1_no_early_done", 32'(done8), 32'd0);
    edges = 0;
    while (done8 !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk("t1_done_latency", 32'(edges), 32'd8);

    // 2: carry ripple
    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // 3: exhaustive WIDTH=4
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(4'(ia), 4'(ib), 1'(ic), 5'(ia + ib + ic));

    // 4: start held high, a changing each cycle; accepts land at cycles 0, 10, 20
    wait_idle8();
    b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h021);
    q8.push_back(9'h02B);
    q8.push_back(9'h035);
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      chk("t4_done_period", 32'(done8), 32'((i % 10) == 9));
      a8 = 8'h10 + 8'(i);
    end
    @(negedge clk);
    start8 = 1'b0;

    // 5/6: held result during run, then abort with reset at bit 3
    op8(8'h5A, 8'h3C, 1'b0, 9'h096);
    wait_idle8();
    chk("t5_prev_result", 32'({cout8, sum8}), 32'h096);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t6_sum_held", 32'({cout8, sum8}), 32'h096);
      chk("t6_busy_run", 32'(busy8), 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_abort_busy", 32'(busy8), 32'd0);
    chk("t5_abort_done", 32'(done8), 32'd0);
    chk("t5_abort_sum", 32'({cout8, sum8}), 32'd0);
    repeat (12) @(negedge clk);
    chk("t5_no_late_done", 32'(done8), 32'd0);
    op8(8'h01, 8'h01, 1'b0, 9'h002);

    // Drain scoreboards
    edges = 0;
    while ((q8.size() != 0 || q4.size() != 0) && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain4", 32'(q4.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
